// File: rtl/vec_alu_seq_if.sv
// vec_alu_seq_if: control, register-file serial ports and status of vec_alu_seq; SatFlag exists only with VEC_ALU_SAT_EN
interface vec_alu_seq_if #(parameter int WIDTH = 16);
  logic Start;
  logic [2:0] Op, Va, Vb, Vd;
  logic [WIDTH-1:0] DataIn_s, DataIn2_s;
  logic [2:0] Addr, Addr2, AddrW;
  logic RD_s, WR_s;
  logic [WIDTH-1:0] DataOut_s;
  logic Busy, Done;
`ifdef VEC_ALU_SAT_EN
  logic SatFlag;
`endif
  modport master (
    output Start, Op, Va, Vb, Vd, DataIn_s, DataIn2_s,
    input Addr, Addr2, AddrW, RD_s, WR_s, DataOut_s, Busy, Done
`ifdef VEC_ALU_SAT_EN
    , input SatFlag
`endif
  );
  modport slave (
    input Start, Op, Va, Vb, Vd, DataIn_s, DataIn2_s,
    output Addr, Addr2, AddrW, RD_s, WR_s, DataOut_s, Busy, Done
`ifdef VEC_ALU_SAT_EN
    , output SatFlag
`endif
  );
endinterface

// File: rtl/vec_alu_seq.sv
// vec_alu_seq: serial vector ALU reading two register-file vectors, buffering results, writing back; VEC_ALU_SAT_EN enables saturating add/sub and SatFlag
module vec_alu_seq #(
  parameter int WIDTH = 16,
  parameter int ELEMS = 16
) (
  input logic Clk,
  input logic Rst_n,
  vec_alu_seq_if.slave bus
);
  localparam int CW = $clog2(ELEMS);
  localparam logic [CW-1:0] LAST = CW'(ELEMS - 1);
  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;
  state_t state, nxt;
  logic [2:0] op;
  logic [CW-1:0] rcnt, ccnt, wcnt;
  logic rd_d1;
  logic [WIDTH-1:0] rbuf [ELEMS];
  logic [WIDTH-1:0] a, b, add_r, sub_r, res;
  assign a = bus.DataIn_s;
  assign b = bus.DataIn2_s;
`ifdef VEC_ALU_SAT_EN
  logic [WIDTH-1:0] sum, dif, clamp;
  logic ovf_s, ovf_d, sat;
  assign sum = a + b;
  assign dif = a - b;
  assign ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
  // overflow direction always follows the sign of A
  assign clamp = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign add_r = ovf_s ? clamp : sum;
  assign sub_r = ovf_d ? clamp : dif;
  assign sat = (op == 3'd0 && ovf_s) || (op == 3'd1 && ovf_d);
`else
  assign add_r = a + b;
  assign sub_r = a - b;
`endif
  always_comb begin
    res = op == 3'd0 ? add_r :
          op == 3'd1 ? sub_r :
          op == 3'd2 ? a & b :
          op == 3'd3 ? a | b :
          op == 3'd4 ? a ^ b :
          op == 3'd5 ? {a[WIDTH-2:0], 1'b0} : a;
  end
  always_comb begin
    nxt = (state == IDLE && bus.Start) ? READ :
          (state == READ && rcnt == LAST) ? DRAIN :
          state == DRAIN ? WRITE :
          (state == WRITE && wcnt == LAST) ? DONE :
          state == DONE ? IDLE : state;
    bus.RD_s = state == READ;
    bus.WR_s = state == WRITE;
    bus.Busy = state inside {READ, DRAIN, WRITE};
    bus.Done = state == DONE;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      op <= '0;
      bus.Addr <= '0;
      bus.Addr2 <= '0;
      bus.AddrW <= '0;
      rcnt <= '0;
      ccnt <= '0;
      wcnt <= '0;
      rd_d1 <= 1'b0;
      bus.DataOut_s <= '0;
`ifdef VEC_ALU_SAT_EN
      bus.SatFlag <= 1'b0;
`endif
    end else begin
      state <= nxt;
      rd_d1 <= bus.RD_s;
      if (state == IDLE && bus.Start) begin
        op <= bus.Op;
        bus.Addr <= bus.Va;
        bus.Addr2 <= bus.Vb;
        bus.AddrW <= bus.Vd;
        rcnt <= '0;
        ccnt <= '0;
        wcnt <= '0;
`ifdef VEC_ALU_SAT_EN
        bus.SatFlag <= 1'b0;
`endif
      end
      if (state == READ) rcnt <= rcnt + 1'b1;
      if (rd_d1) ccnt <= ccnt + 1'b1;
      if (state == WRITE) wcnt <= wcnt + 1'b1;
      // output is registered, so load one element ahead of the write cycle
      if (state == DRAIN || (state == WRITE && wcnt != LAST))
        bus.DataOut_s <= rbuf[state == DRAIN ? '0 : wcnt + 1'b1];
`ifdef VEC_ALU_SAT_EN
      if (rd_d1 && sat) bus.SatFlag <= 1'b1;
`endif
    end
  end
  always_ff @(posedge Clk) begin
    if (rd_d1) rbuf[ccnt] <= res;
  end
endmodule

// File: tb/tb_vec_alu_seq.sv
// tb_vec_alu_seq: scoreboard bench with a behavioural register file around vec_alu_seq
module tb_vec_alu_seq;
  localparam int W = 16;
  localparam int N = 16;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  vec_alu_seq_if #(.WIDTH(W)) bus();
  vec_alu_seq #(.WIDTH(W), .ELEMS(N)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
  always #5 Clk = ~Clk;
  logic [W-1:0] regs [8][N];
  logic [W-1:0] q [$];
  logic [W-1:0] mon_e;
  int n_cmp = 0;
  int n_err = 0;
  int rk = 0;
  int wk = 0;
  logic rd_q = 1'b0;
  logic [2:0] ra_q = '0;
  logic [2:0] rb_q = '0;
  logic exp_sat;

  function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef VEC_ALU_SAT_EN
    int r;
    if (op < 3'd2) begin
      r = op == 3'd0 ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
      if (r > 32767) return {1'b1, 16'h7FFF};
      if (r < -32768) return {1'b1, 16'h8000};
      return {1'b0, r[W-1:0]};
    end
`endif
    case (op)
      3'd0: return {1'b0, W'(a + b)};
      3'd1: return {1'b0, W'(a - b)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, a[W-2:0], 1'b0};
      default: return {1'b0, a};
    endcase
  endfunction

  always @(negedge Clk) begin
    rd_q = bus.RD_s;
    ra_q = bus.Addr;
    rb_q = bus.Addr2;
  end

  always @(posedge Clk) begin
    #1;
    if (rd_q && rk < N) begin
      bus.DataIn_s = regs[ra_q][rk];
      bus.DataIn2_s = regs[rb_q][rk];
      rk++;
    end else begin
      rk = 0;
      bus.DataIn_s = W'($urandom);
      bus.DataIn2_s = W'($urandom);
    end
  end

  always @(negedge Clk) begin
    if (bus.WR_s) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL wr_data: unexpected write got=%h required=none", bus.DataOut_s);
      end else begin
        mon_e = q.pop_front();
        if (bus.DataOut_s !== mon_e) begin
          n_err++;
          $display("FAIL wr_data: elem=%0d got=%h required=%h", wk, bus.DataOut_s, mon_e);
        end
      end
      if (wk < N) regs[bus.AddrW][wk] = bus.DataOut_s;
      wk++;
    end else wk = 0;
  end

  task automatic op_run(input logic [2:0] op, input logic [2:0] va, input logic [2:0] vb, input logic [2:0] vd,
                        input int s1, input int s2, input int rst_at);
    logic [W:0] m;
    logic [12:0] got, exp;
    exp_sat = 1'b0;
    for (int k = 0; k < N; k++) begin
      m = model(op, regs[va][k], regs[vb][k]);
      q.push_back(m[W-1:0]);
      exp_sat |= m[W];
    end
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op = op;
    bus.Va = va;
    bus.Vb = vb;
    bus.Vd = vd;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
      bus.Vd = vd;
      got = {bus.RD_s, bus.WR_s, bus.Busy, bus.Done, bus.Addr, bus.Addr2, bus.AddrW};
      exp = {c <= 16, c >= 18 && c <= 33, c <= 33, c == 34, va, vb, vd};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL ctrl: cycle=%0d got=%h required=%h", c, got, exp);
      end
      if (c == rst_at) begin
        #2 Rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.RD_s, bus.WR_s, bus.Busy, bus.Done, bus.DataOut_s} !== '0) begin
          n_err++;
          $display("FAIL async_rst: got rd/wr/busy/done/data=%b%b%b%b/%h required=0",
                   bus.RD_s, bus.WR_s, bus.Busy, bus.Done, bus.DataOut_s);
        end
        q.delete();
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        return;
      end
      if (c == s1 || c == s2) begin
        bus.Start = 1'b1;
        bus.Vd = ~vd;
      end
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: leftover=%0d required=0", q.size());
      q.delete();
    end
`ifdef VEC_ALU_SAT_EN
    n_cmp++;
    if (bus.SatFlag !== exp_sat) begin
      n_err++;
      $display("FAIL satflag: got=%b required=%b", bus.SatFlag, exp_sat);
    end
`endif
  endtask

  task automatic test_reset();
    bus.Start = 1'b0;
    bus.Op = '0;
    bus.Va = '0;
    bus.Vb = '0;
    bus.Vd = '0;
    Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    n_cmp++;
    if ({bus.RD_s, bus.WR_s, bus.Busy, bus.Done, bus.Addr, bus.Addr2, bus.AddrW, bus.DataOut_s} !== '0) begin
      n_err++;
      $display("FAIL reset: got rd/wr/busy/done=%b%b%b%b addr=%0d/%0d/%0d data=%h required=all zero",
               bus.RD_s, bus.WR_s, bus.Busy, bus.Done, bus.Addr, bus.Addr2, bus.AddrW, bus.DataOut_s);
    end
    Rst_n = 1'b1;
  endtask

  task automatic test_add();
    for (int k = 0; k < N; k++) begin
      regs[1][k] = W'(k);
      regs[2][k] = 16'h0100;
    end
    op_run(3'd0, 3'd1, 3'd2, 3'd3, 0, 0, 0);
    @(negedge Clk);
    n_cmp++;
    if (bus.DataOut_s !== 16'h010F || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      n_err++;
      $display("FAIL add_hold: got data=%h busy=%b done=%b required=010f 0 0", bus.DataOut_s, bus.Busy, bus.Done);
    end
  endtask

  task automatic test_inplace_xor();
    for (int k = 0; k < N; k++) regs[0][k] = 16'hA000 + W'(k);
    op_run(3'd4, 3'd0, 3'd0, 3'd0, 0, 0, 0);
    n_cmp++;
    if (regs[0][9] !== 16'h0000) begin
      n_err++;
      $display("FAIL inplace_xor: got=%h required=0000", regs[0][9]);
    end
  endtask

  task automatic test_wrap();
`ifdef VEC_ALU_SAT_EN
    for (int k = 0; k < N; k++) begin
      regs[4][k] = 16'h7FFF;
      regs[5][k] = 16'h0001;
    end
    op_run(3'd0, 3'd4, 3'd5, 3'd6, 0, 0, 0);
    n_cmp++;
    if (regs[6][0] !== 16'h7FFF || bus.SatFlag !== 1'b1) begin
      n_err++;
      $display("FAIL sat_add: got=%h flag=%b required=7fff 1", regs[6][0], bus.SatFlag);
    end
    for (int k = 0; k < N; k++) regs[4][k] = 16'h8000;
    op_run(3'd1, 3'd4, 3'd5, 3'd6, 0, 0, 0);
    n_cmp++;
    if (regs[6][15] !== 16'h8000) begin
      n_err++;
      $display("FAIL sat_sub: got=%h required=8000", regs[6][15]);
    end
`else
    for (int k = 0; k < N; k++) begin
      regs[4][k] = 16'hFFFF;
      regs[5][k] = 16'h0002;
    end
    op_run(3'd0, 3'd4, 3'd5, 3'd6, 0, 0, 0);
    n_cmp++;
    if (regs[6][0] !== 16'h0001) begin
      n_err++;
      $display("FAIL wrap: got=%h required=0001", regs[6][0]);
    end
`endif
  endtask

  task automatic test_ignored_start();
    for (int k = 0; k < N; k++) regs[1][k] = W'($urandom);
    op_run(3'd3, 3'd1, 3'd2, 3'd5, 5, 34, 0);
    @(negedge Clk);
    bus.Start = 1'b0;
    n_cmp++;
    if ({bus.RD_s, bus.WR_s, bus.Busy, bus.Done} !== 4'b0000) begin
      n_err++;
      $display("FAIL ignored_start: got rd/wr/busy/done=%b%b%b%b required=0000",
               bus.RD_s, bus.WR_s, bus.Busy, bus.Done);
    end
    op_run(3'd1, 3'd1, 3'd2, 3'd4, 0, 0, 0);
  endtask

  task automatic test_reset_mid_write();
    op_run(3'd0, 3'd1, 3'd2, 3'd3, 0, 0, 25);
    op_run(3'd2, 3'd1, 3'd2, 3'd7, 0, 0, 0);
  endtask

  task automatic test_reserved();
    for (int k = 0; k < N; k++) begin
      regs[6][k] = 16'h1234;
      regs[7][k] = W'($urandom);
    end
    op_run(3'd7, 3'd6, 3'd7, 3'd5, 0, 0, 0);
    n_cmp++;
    if (regs[5][15] !== 16'h1234) begin
      n_err++;
      $display("FAIL reserved: got=%h required=1234", regs[5][15]);
    end
  endtask

  task automatic test_ops();
    for (int o = 0; o < 8; o++) begin
      for (int k = 0; k < N; k++) begin
        regs[2][k] = W'($urandom);
        regs[3][k] = W'($urandom);
      end
      op_run(3'(o), 3'd2, 3'd3, 3'(o), 0, 0, 0);
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < N; k++) regs[r][k] = '0;
    test_reset();
    test_add();
    test_inplace_xor();
    test_wrap();
    test_ignored_start();
    test_reset_mid_write();
    test_reserved();
    test_ops();
    repeat (2) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
